rv_csr_access: RTL



---
 rtl/rv_csr_access_if.sv | 41 ++++
 rtl/rv_csr_access.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_csr_access_if.sv
// ---------------------------------------------------------------------------
// rv_csr_access_if
// Purpose : Request/response handshake bundle between the execute stage and
//           the CSR access unit (rv_csr_access).
// Signals :
//   i_req_valid  execute -> unit   CSR access request
//   o_req_ready  unit -> execute   unit idle; request taken on valid&ready
//   i_req_addr   execute -> unit   12-bit CSR address
//   i_req_op     execute -> unit   01=RW 10=RS 11=RC 00=reserved
//   i_req_wdata  execute -> unit   rs1 value or zero-extended zimm
//   i_req_wr_en  execute -> unit   0 when the rs1/zimm field is x0
//   o_rsp_valid  unit -> execute   response valid
//   i_rsp_ready  execute -> unit   response consumed
//   o_rsp_rdata  unit -> execute   old CSR value for rd
//   o_rsp_illegal unit -> execute  raise illegal-instruction
// Modports: slave (the CSR unit), master (the requester / testbench).
// ---------------------------------------------------------------------------
interface rv_csr_access_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [11:0] i_req_addr;
    logic [1:0]  i_req_op;
    logic [31:0] i_req_wdata;
    logic        i_req_wr_en;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_illegal;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_op, i_req_wdata, i_req_wr_en,
        input  i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_illegal
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_op, i_req_wdata, i_req_wr_en,
        output i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_illegal
    );
endinterface

// File: rtl/rv_csr_access.sv
// ---------------------------------------------------------------------------
// rv_csr_access
// Purpose : CSR instruction access unit sitting between the execute stage and
//           CSR storage. Sequences CSRRW/CSRRS/CSRRC, one access in flight.
//           Counter CSRs are read through an external counter bank (index
//           out, combinational data in); mscratch and mcountinhibit are held
//           locally.
// Ports   :
//   i_clk          clock
//   i_reset        asynchronous, active-high reset
//   bus            rv_csr_access_if.slave request/response handshake
//   o_cnt_idx      [7:0]  counter bank read index (8'hFF = not a counter)
//   i_cnt_data     [31:0] counter bank read data, combinational from o_cnt_idx
//   o_cnt_inhibit  [2:0]  {instret inhibit, 0, cycle inhibit}
// Parameters:
//   MSCRATCH_RST   reset value of mscratch (0x340)
// Configuration macro:
//   CSR_MCOUNTINHIBIT_EN  defined   -> 0x320 implements CY[0] and IR[2]
//                         undefined -> 0x320 reads 0, writes ignored
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a request; latches it and drives the counter index
// LOOKUP | counter data valid; picks old value, decides illegal, commits
// RESP   | response held stable until the requester takes it
// ---------------------------------------------------------------------------
module rv_csr_access #(
    parameter logic [31:0] MSCRATCH_RST = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    rv_csr_access_if.slave    bus,
    output logic [7:0]        o_cnt_idx,
    input  logic [31:0]       i_cnt_data,
    output logic [2:0]        o_cnt_inhibit
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_illegal;
    logic [7:0]  r_cnt_idx;

    // Latched request. Only the top two address bits matter once the
    // address has been classified.
    logic [1:0]  r_addr_hi;
    logic [1:0]  r_op;
    logic [31:0] r_wdata;
    logic        r_wr_en;
    logic        r_is_cnt;
    logic        r_is_scratch;
    logic        r_is_inhibit;

    logic [31:0] r_mscratch;

    logic        w_is_cnt;
    logic        w_is_scratch;
    logic        w_is_inhibit;
    logic [7:0]  w_idx;
    logic        w_accept;
    logic        w_write;
    logic        w_illegal;
    logic        w_commit;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [31:0] w_inhibit_val;

    assign w_accept = bus.i_req_valid && r_req_ready;

    // Address classification on the incoming request.
    always_comb begin
        w_is_cnt     = 1'b0;
        w_is_scratch = 1'b0;
        w_is_inhibit = 1'b0;
        w_idx        = 8'hFF;
        case (bus.i_req_addr)
            12'hC00, 12'hC01, 12'hC02,
            12'hC80, 12'hC81, 12'hC82: begin
                w_is_cnt = 1'b1;
                w_idx    = bus.i_req_addr[7:0];
            end
            12'h340: w_is_scratch = 1'b1;
            12'h320: w_is_inhibit = 1'b1;
            default: ;
        endcase
    end

    // RW always writes; RS/RC write only when the source field is not x0.
    assign w_write = (r_op == OP_RW) ||
                     (((r_op == OP_RS) || (r_op == OP_RC)) && r_wr_en);

    assign w_illegal = !(r_is_cnt || r_is_scratch || r_is_inhibit) ||
                       (r_op == OP_NONE) ||
                       (w_write && (r_addr_hi == 2'b11));

    always_comb begin
        w_old = 32'h0;
        if (r_is_cnt) begin
            w_old = i_cnt_data;
        end else if (r_is_scratch) begin
            w_old = r_mscratch;
        end else if (r_is_inhibit) begin
            w_old = w_inhibit_val;
        end
    end

    always_comb begin
        w_new = w_old;
        case (r_op)
            OP_RW:   w_new = r_wdata;
            OP_RS:   w_new = w_old | r_wdata;
            OP_RC:   w_new = w_old & ~r_wdata;
            default: w_new = w_old;
        endcase
    end

    assign w_commit = (r_state == S_LOOKUP) && w_write && !w_illegal;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_illegal <= 1'b0;
            r_cnt_idx     <= 8'h00;
            r_addr_hi     <= 2'b00;
            r_op          <= OP_NONE;
            r_wdata       <= 32'h0;
            r_wr_en       <= 1'b0;
            r_is_cnt      <= 1'b0;
            r_is_scratch  <= 1'b0;
            r_is_inhibit  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr_hi    <= bus.i_req_addr[11:10];
                        r_op         <= bus.i_req_op;
                        r_wdata      <= bus.i_req_wdata;
                        r_wr_en      <= bus.i_req_wr_en;
                        r_is_cnt     <= w_is_cnt;
                        r_is_scratch <= w_is_scratch;
                        r_is_inhibit <= w_is_inhibit;
                        r_cnt_idx    <= w_idx;
                        r_req_ready  <= 1'b0;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_rsp_rdata   <= w_illegal ? 32'h0 : w_old;
                    r_rsp_illegal <= w_illegal;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    // Ready only rises on the way back to IDLE, so a request
                    // presented during the response handshake waits a cycle.
                    if (bus.i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mscratch <= MSCRATCH_RST;
        end else if (w_commit && r_is_scratch) begin
            r_mscratch <= w_new;
        end
    end

`ifdef CSR_MCOUNTINHIBIT_EN
    logic r_inh_cy;
    logic r_inh_ir;

    // Only CY and IR are writable; every other bit reads back as zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_inh_cy <= 1'b0;
            r_inh_ir <= 1'b0;
        end else if (w_commit && r_is_inhibit) begin
            r_inh_cy <= w_new[0];
            r_inh_ir <= w_new[2];
        end
    end

    assign w_inhibit_val = {29'h0, r_inh_ir, 1'b0, r_inh_cy};
    assign o_cnt_inhibit = {r_inh_ir, 1'b0, r_inh_cy};
`else
    // 0x320 is mapped but empty: reads zero, writes are silently dropped.
    assign w_inhibit_val = 32'h0;
    assign o_cnt_inhibit = 3'b000;
`endif

    assign bus.o_req_ready   = r_req_ready;
    assign bus.o_rsp_valid   = r_rsp_valid;
    assign bus.o_rsp_rdata   = r_rsp_rdata;
    assign bus.o_rsp_illegal = r_rsp_illegal;
    assign o_cnt_idx         = r_cnt_idx;

endmodule
